// File: rtl/mole_round_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mole_round_controller
//  Description : Whack-A-Mole round sequencer: picks a pseudo-random hole,
//                opens a timed hit window, scores hits/misses over a game.
//  Revision    : 1.0  initial release
// ============================================================================
module mole_round_controller #(
    parameter int          NUM_HOLES     = 5,
    parameter int          WINDOW_CYCLES = 100,
    parameter int          GAP_CYCLES    = 20,
    parameter int          ROUNDS        = 16,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       pulse,
    output logic [2:0] selector,
    output logic       mole_on,
    output logic [7:0] hit_count,
    output logic [7:0] miss_count,
    output logic [7:0] round_idx,
    output logic       busy,
    output logic       done
);

    localparam int         c_TIMER_MAX = (WINDOW_CYCLES > GAP_CYCLES) ? WINDOW_CYCLES : GAP_CYCLES;
    localparam int         c_TIMER_W   = (c_TIMER_MAX > 2) ? $clog2(c_TIMER_MAX) : 1;
    localparam logic [c_TIMER_W-1:0] c_WIN_LOAD = c_TIMER_W'(WINDOW_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_GAP_LOAD = c_TIMER_W'(GAP_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_ONE      = c_TIMER_W'(1);
    localparam logic [2:0] c_NUM_HOLES = 3'(NUM_HOLES);
    localparam logic [7:0] c_ROUNDS    = 8'(ROUNDS);
    localparam logic [2:0] c_NO_HOLE   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PICK = 3'd1,
        S_SHOW = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                 r_state;
    logic [7:0]             r_lfsr;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [2:0]             r_prev_hole;

    logic                   w_fb;
    logic [2:0]             w_cand;
    logic                   w_cand_ok;

    // Fibonacci LFSR, taps 8,6,5,4; low three bits propose the next hole
    assign w_fb      = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_cand    = r_lfsr[2:0];
    assign w_cand_ok = (w_cand < c_NUM_HOLES) && (w_cand != r_prev_hole);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_lfsr      <= LFSR_SEED;
            r_timer     <= '0;
            r_prev_hole <= c_NO_HOLE;
            selector    <= c_NO_HOLE;
            mole_on     <= 1'b0;
            hit_count   <= 8'd0;
            miss_count  <= 8'd0;
            round_idx   <= 8'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        hit_count  <= 8'd0;
                        miss_count <= 8'd0;
                        round_idx  <= 8'd0;
                        done       <= 1'b0;
                        busy       <= 1'b1;
                        r_state    <= S_PICK;
                    end
                end
                S_PICK: begin
                    // Rejected candidates simply wait for the next LFSR step
                    if (w_cand_ok) begin
                        selector    <= w_cand;
                        r_prev_hole <= w_cand;
                        mole_on     <= 1'b1;
                        r_timer     <= c_WIN_LOAD;
                        r_state     <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (pulse || (r_timer == '0)) begin
                        if (pulse) begin
                            if (hit_count != 8'hFF)
                                hit_count <= hit_count + 8'd1;
                        end else begin
                            if (miss_count != 8'hFF)
                                miss_count <= miss_count + 8'd1;
                        end
                        if (round_idx != 8'hFF)
                            round_idx <= round_idx + 8'd1;
                        mole_on  <= 1'b0;
                        selector <= c_NO_HOLE;
                        r_timer  <= c_GAP_LOAD;
                        r_state  <= S_GAP;
                    end else begin
                        r_timer <= r_timer - c_ONE;
                    end
                end
                S_GAP: begin
                    if (r_timer == '0) begin
                        if (round_idx == c_ROUNDS) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_PICK;
                        end
                    end else begin
                        r_timer <= r_timer - c_ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mole_round_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mole_round_controller
//  Description : Scoreboard bench for mole_round_controller with a round-level
//                reference model (hole choice, window length, outcome, timing).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mole_round_controller;

    localparam int         NH   = 5;
    localparam int         W    = 10;
    localparam int         G    = 4;
    localparam int         R    = 3;
    localparam logic [7:0] SEED = 8'hA5;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       pulse;
    logic [2:0] selector;
    logic       mole_on;
    logic [7:0] hit_count;
    logic [7:0] miss_count;
    logic [7:0] round_idx;
    logic       busy;
    logic       done;

    mole_round_controller #(
        .NUM_HOLES    (NH),
        .WINDOW_CYCLES(W),
        .GAP_CYCLES   (G),
        .ROUNDS       (R),
        .LFSR_SEED    (SEED)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .pulse     (pulse),
        .selector  (selector),
        .mole_on   (mole_on),
        .hit_count (hit_count),
        .miss_count(miss_count),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outcome of one round, pushed by stimulus, popped by the monitor
    typedef struct {
        bit hit;
        int len;
    } exp_t;
    exp_t sb_q[$];

    // Reference random source: value the design sees at edge number n
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    int         ecount;
    logic [7:0] m_lfsr;
    logic [7:0] hist [0:65535];

    always @(posedge clock) begin
        if (reset) begin
            ecount = 0;
            m_lfsr = SEED;
        end else begin
            ecount++;
            if (ecount < 65536) hist[ecount] = m_lfsr;
            m_lfsr = lfsr_next(m_lfsr);
        end
    end

    // ---------------- monitor ----------------
    bit pm, pb, pd;
    int pick_from, rise_edge, last_fall;
    int m_prev, m_hit, m_miss, m_rnd;

    always @(negedge clock) begin
        if (reset) begin
            pm = 0; pb = 0; pd = 0;
            m_prev = 7; m_hit = 0; m_miss = 0; m_rnd = 0;
            pick_from = 0; rise_edge = 0; last_fall = 0;
        end else begin
            chk(int'(hit_count) + int'(miss_count) == int'(round_idx), "count_invariant",
                int'(hit_count) + int'(miss_count), int'(round_idx));
            if (mole_on) chk(int'(selector) < NH, "selector_in_range", int'(selector), NH - 1);
            else         chk(selector == 3'd7, "selector_idle", int'(selector), 7);

            if (busy && !pb) begin
                pick_from = ecount + 1;
                m_hit = 0; m_miss = 0; m_rnd = 0;
                chk(round_idx == 8'd0 && hit_count == 8'd0 && miss_count == 8'd0,
                    "counts_cleared_on_start", int'(round_idx), 0);
                chk(done == 1'b0, "done_cleared_on_start", int'(done), 0);
            end

            if (mole_on && !pm) begin
                int e;
                int exp_sel;
                e = pick_from;
                while (e < ecount && !(int'(hist[e][2:0]) < NH && int'(hist[e][2:0]) != m_prev)) e++;
                exp_sel = int'(hist[e][2:0]);
                chk(e == ecount, "mole_rise_time", ecount, e);
                chk(int'(selector) == exp_sel, "picked_hole", int'(selector), exp_sel);
                chk(int'(selector) != m_prev, "hole_not_repeated", int'(selector), m_prev);
                m_prev = exp_sel;
                rise_edge = ecount;
            end

            if (!mole_on && pm) begin
                if (sb_q.size() == 0) begin
                    chk(1'b0, "unexpected_round", 1, 0);
                end else begin
                    exp_t x;
                    x = sb_q.pop_front();
                    chk(ecount - rise_edge == x.len, "window_len", ecount - rise_edge, x.len);
                    if (x.hit) m_hit++; else m_miss++;
                    m_rnd++;
                    chk(int'(hit_count) == m_hit, "hit_count", int'(hit_count), m_hit);
                    chk(int'(miss_count) == m_miss, "miss_count", int'(miss_count), m_miss);
                    chk(int'(round_idx) == m_rnd, "round_idx", int'(round_idx), m_rnd);
                end
                last_fall = ecount;
                pick_from = ecount + G + 1;
            end

            if (done && !pd) begin
                chk(ecount == last_fall + G, "done_time", ecount, last_fall + G);
                chk(busy == 1'b0, "busy_at_done", int'(busy), 0);
                chk(int'(round_idx) == R, "rounds_at_done", int'(round_idx), R);
            end

            pm = mole_on; pb = busy; pd = done;
        end
    end

    // ---------------- stimulus ----------------
    // mode 0: never pulse; 1: pulse 2 clocks into window; 2: pulse held outside
    // windows only; 3: pulse in final window cycle and again in the gap; 4: random
    task automatic drive_idle(input int mode);
        if (mode == 2 || mode == 3) pulse = 1'b1;
        else if (mode == 4)         pulse = 1'($urandom_range(0, 1));
        else                        pulse = 1'b0;
        start = (mode == 4 && busy && $urandom_range(0, 7) == 0);
    endtask

    task automatic run_game(input int mode, input int rst_round);
        int k;
        int g;
        int j;
        drive_idle(mode);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int r = 0; r < R; r++) begin
            case (mode)
                1:       k = 2;
                3:       k = W - 1;
                4:       k = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, W - 1));
                default: k = -1;
            endcase
            sb_q.push_back('{hit: (k >= 0), len: ((k >= 0) ? k + 1 : W)});
            g = 0;
            while (!mole_on) begin
                drive_idle(mode);
                @(negedge clock);
                g++;
                if (g > 200) begin
                    chk(1'b0, "mole_rise_timeout", g, 200);
                    return;
                end
            end
            j = 0;
            while (1) begin
                if (r == rst_round && j == 3) begin
                    #2;
                    reset = 1'b1;
                    pulse = 1'b0;
                    start = 1'b0;
                    #1;
                    chk(mole_on == 1'b0, "reset_mole_on", int'(mole_on), 0);
                    chk(selector == 3'd7, "reset_selector", int'(selector), 7);
                    chk(hit_count == 8'd0 && miss_count == 8'd0, "reset_counts",
                        int'(hit_count) + int'(miss_count), 0);
                    chk(round_idx == 8'd0, "reset_round_idx", int'(round_idx), 0);
                    chk(busy == 1'b0 && done == 1'b0, "reset_busy_done", int'({busy, done}), 0);
                    sb_q.delete();
                    @(negedge clock);
                    @(negedge clock);
                    reset = 1'b0;
                    return;
                end
                pulse = (j == k);
                start = (mode == 4 && busy && $urandom_range(0, 7) == 0);
                @(negedge clock);
                j++;
                if (!mole_on) break;
                if (j > W + 2) begin
                    chk(1'b0, "window_timeout", j, W);
                    return;
                end
            end
        end
        g = 0;
        while (!done) begin
            drive_idle(mode);
            @(negedge clock);
            g++;
            if (g > 200) begin
                chk(1'b0, "done_timeout", g, 200);
                return;
            end
        end
        pulse = 1'b0;
        start = 1'b0;
        chk(busy == 1'b0, "game_end_busy", int'(busy), 0);
        if (mode == 0 || mode == 2) begin
            chk(int'(miss_count) == R, "game_misses", int'(miss_count), R);
            chk(int'(hit_count) == 0, "game_hits", int'(hit_count), 0);
        end else if (mode == 1 || mode == 3) begin
            chk(int'(hit_count) == R, "game_hits", int'(hit_count), R);
            chk(int'(miss_count) == 0, "game_misses", int'(miss_count), 0);
        end
        @(negedge clock);
        chk(done == 1'b1, "done_held", int'(done), 1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        pulse = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk(selector == 3'd7, "rst_selector", int'(selector), 7);
        chk(mole_on == 1'b0, "rst_mole_on", int'(mole_on), 0);
        chk(hit_count == 8'd0 && miss_count == 8'd0 && round_idx == 8'd0, "rst_counts",
            int'(hit_count) + int'(miss_count) + int'(round_idx), 0);
        chk(busy == 1'b0 && done == 1'b0, "rst_busy_done", int'({busy, done}), 0);
        @(negedge clock);

        run_game(0, -1);
        run_game(1, -1);
        run_game(2, -1);
        run_game(3, -1);
        run_game(4, 1);
        run_game(0, -1);
        for (int n = 0; n < 10; n++) run_game(4, -1);

        repeat (3) @(negedge clock);
        chk(sb_q.size() == 0, "scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=%0t required_below=500000", $time);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
